// File: rtl/paint_ctrl.sv
// rtl/paint_ctrl.sv - cursor, pen-write and full-screen clear sequencer for the paint framebuffer
//
// Purpose:
//   Converts debounced direction levels into an 8-bit x/y cursor with
//   press-and-hold auto-repeat. Owns the single 256x256x12 framebuffer write
//   port and shares it between pen drawing and a full-screen clear engine.
//
// Optional feature macro:
//   CURSOR_WRAP_EN  defined   -> cursor wraps modulo 256 at the edges
//                   undefined -> cursor saturates at 0 and 255
//
// Ports:
//   clk                    system clock
//   rst                    synchronous, active-high reset
//   up, down, left, right  debounced direction levels
//   draw                   pen-down level
//   color[11:0]            pen colour {R,G,B}
//   clear                  clear-request level, rising-edge triggered
//   x[7:0], y[7:0]         cursor position
//   valid                  cursor visible (low while clearing)
//   we                     framebuffer write enable
//   waddr[15:0]            framebuffer write address {y,x}
//   wdata[11:0]            framebuffer write data
//   busy                   clear in progress

module paint_ctrl #(
    parameter int          MOVE_PERIOD = 5_000_000,
    parameter logic [11:0] CLEAR_COLOR = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        draw,
    input  logic [11:0] color,
    input  logic        clear,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic        valid,
    output logic        we,
    output logic [15:0] waddr,
    output logic [11:0] wdata,
    output logic        busy
);

    localparam int              CNT_W    = $clog2(MOVE_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [7:0]        x_d, y_d;
    logic              valid_d, we_d, busy_d;
    logic [15:0]       waddr_d;
    logic [11:0]       wdata_d;
    logic [CNT_W-1:0]  rpt_cnt, rpt_cnt_d;
    logic [15:0]       clr_ptr, clr_ptr_d;

    logic prev_up, prev_down, prev_left, prev_right, prev_clear;
    logic rise_up, rise_down, rise_left, rise_right, rise_clear;
    logic any_dir, tick;
    logic mv_up, mv_down, mv_left, mv_right;

    // One cursor step along an axis; opposing requests cancel.
    function automatic logic [7:0] step_pos(input logic [7:0] pos,
                                            input logic       inc,
                                            input logic       dec);
        logic [7:0] r;
        r = pos;
        if (inc && !dec) begin
`ifdef CURSOR_WRAP_EN
            r = pos + 8'd1;
`else
            if (pos != 8'hFF) r = pos + 8'd1;
`endif
        end else if (dec && !inc) begin
`ifdef CURSOR_WRAP_EN
            r = pos - 8'd1;
`else
            if (pos != 8'h00) r = pos - 8'd1;
`endif
        end
        return r;
    endfunction

    assign rise_up    = up    & ~prev_up;
    assign rise_down  = down  & ~prev_down;
    assign rise_left  = left  & ~prev_left;
    assign rise_right = right & ~prev_right;
    assign rise_clear = clear & ~prev_clear;

    assign any_dir = up | down | left | right;
    // Auto-repeat tick: every held direction steps together.
    assign tick    = any_dir && (rpt_cnt == CNT_LAST);

    assign mv_up    = rise_up    | (tick & up);
    assign mv_down  = rise_down  | (tick & down);
    assign mv_left  = rise_left  | (tick & left);
    assign mv_right = rise_right | (tick & right);

    always_comb begin
        state_d   = state;
        x_d       = x;
        y_d       = y;
        valid_d   = valid;
        we_d      = we;
        waddr_d   = waddr;
        wdata_d   = wdata;
        busy_d    = busy;
        rpt_cnt_d = rpt_cnt;
        clr_ptr_d = clr_ptr;

        case (state)
            IDLE: begin
                if (rise_clear) begin
                    // Clear takes the port this cycle; pen and motion are dropped.
                    state_d   = CLEAR;
                    busy_d    = 1'b1;
                    valid_d   = 1'b0;
                    we_d      = 1'b1;
                    waddr_d   = 16'h0000;
                    wdata_d   = CLEAR_COLOR;
                    clr_ptr_d = 16'h0001;
                    rpt_cnt_d = '0;
                end else begin
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    // Pen writes the pre-move position, so a moving pen
                    // paints the pixel being left.
                    we_d    = draw;
                    waddr_d = {y, x};
                    wdata_d = color;
                    x_d     = step_pos(x, mv_right, mv_left);
                    y_d     = step_pos(y, mv_down, mv_up);
                    if (!any_dir || tick) rpt_cnt_d = '0;
                    else                  rpt_cnt_d = rpt_cnt + 1'b1;
                end
            end

            CLEAR: begin
                rpt_cnt_d = '0;
                if (waddr == 16'hFFFF) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    waddr_d   = clr_ptr;
                    clr_ptr_d = clr_ptr + 16'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            x          <= 8'd128;
            y          <= 8'd128;
            valid      <= 1'b1;
            we         <= 1'b0;
            waddr      <= 16'h0000;
            wdata      <= 12'h000;
            busy       <= 1'b0;
            rpt_cnt    <= '0;
            clr_ptr    <= 16'h0000;
            prev_up    <= 1'b0;
            prev_down  <= 1'b0;
            prev_left  <= 1'b0;
            prev_right <= 1'b0;
            prev_clear <= 1'b0;
        end else begin
            state      <= state_d;
            x          <= x_d;
            y          <= y_d;
            valid      <= valid_d;
            we         <= we_d;
            waddr      <= waddr_d;
            wdata      <= wdata_d;
            busy       <= busy_d;
            rpt_cnt    <= rpt_cnt_d;
            clr_ptr    <= clr_ptr_d;
            // Edge history tracks inputs in every state, so presses made
            // during a clear are consumed there and lost.
            prev_up    <= up;
            prev_down  <= down;
            prev_left  <= left;
            prev_right <= right;
            prev_clear <= clear;
        end
    end

endmodule

// File: tb/tb_paint_ctrl.sv
// tb/tb_paint_ctrl.sv - self-checking bench for paint_ctrl
module tb_paint_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        up, down, left, right, draw, clear;
    logic [11:0] color;
    logic [7:0]  x, y;
    logic        valid, we, busy;
    logic [15:0] waddr;
    logic [11:0] wdata;

    int checks = 0;
    int errors = 0;

    paint_ctrl #(.MOVE_PERIOD(4), .CLEAR_COLOR(12'hFFF)) dut (
        .clk(clk), .rst(rst),
        .up(up), .down(down), .left(left), .right(right),
        .draw(draw), .color(color), .clear(clear),
        .x(x), .y(y), .valid(valid), .we(we),
        .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        up, down, left, right, draw;
        logic [11:0] color;
        logic [7:0]  ex, ey;
        logic        ewe;
        logic [15:0] ewaddr;
        logic [11:0] ewdata;
    } vec_t;

    vec_t vecs[11];

    logic [27:0] sb_q[$];
    logic        sb_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pen-write scoreboard: expected {waddr,wdata} pushed at drive time.
    always @(negedge clk) begin
        if (sb_en && we === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write actual=%0h required=none", waddr);
            end else begin
                logic [27:0] e;
                e = sb_q.pop_front();
                chk("sb_waddr", {16'h0, waddr}, {16'h0, e[27:12]});
                chk("sb_wdata", {20'h0, wdata}, {20'h0, e[11:0]});
            end
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        up = 0; down = 0; left = 0; right = 0; draw = 0; clear = 0; color = 12'h000;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick1();
        tick1();
        rst = 0;
    endtask

    function automatic vec_t mk(logic u, logic d, logic l, logic r, logic dr, logic [11:0] c,
                                logic [7:0] ex, logic [7:0] ey, logic ewe,
                                logic [15:0] ea, logic [11:0] ed);
        vec_t v;
        v.up = u; v.down = d; v.left = l; v.right = r; v.draw = dr; v.color = c;
        v.ex = ex; v.ey = ey; v.ewe = ewe; v.ewaddr = ea; v.ewdata = ed;
        return v;
    endfunction

    initial begin
        int n;
        int bad;
        logic [7:0] edge_exp;

        //          u d l r dr color    x      y     we waddr     wdata
        vecs[0]  = mk(0,0,0,1,0,12'h000, 8'd129,8'd128,0,16'h8080,12'h000);
        vecs[1]  = mk(0,0,0,0,0,12'h000, 8'd129,8'd128,0,16'h8081,12'h000);
        vecs[2]  = mk(0,0,0,0,1,12'h0F0, 8'd129,8'd128,1,16'h8081,12'h0F0);
        vecs[3]  = mk(0,0,1,0,1,12'h0F0, 8'd128,8'd128,1,16'h8081,12'h0F0);
        vecs[4]  = mk(0,0,0,0,1,12'h00F, 8'd128,8'd128,1,16'h8080,12'h00F);
        vecs[5]  = mk(1,1,0,0,0,12'h000, 8'd128,8'd128,0,16'h8080,12'h000);
        vecs[6]  = mk(1,0,0,1,0,12'h000, 8'd129,8'd128,0,16'h8080,12'h000);
        vecs[7]  = mk(1,0,0,1,0,12'h000, 8'd129,8'd128,0,16'h8081,12'h000);
        vecs[8]  = mk(1,0,0,1,0,12'h000, 8'd130,8'd127,0,16'h8081,12'h000);
        vecs[9]  = mk(0,0,0,0,0,12'h000, 8'd130,8'd127,0,16'h7F82,12'h000);
        vecs[10] = mk(0,1,1,0,0,12'h000, 8'd129,8'd128,0,16'h7F82,12'h000);

        // Reset values
        idle_inputs();
        rst = 1;
        tick1();
        tick1();
        chk("rst_x", {24'h0, x}, 32'd128);
        chk("rst_y", {24'h0, y}, 32'd128);
        chk("rst_valid", {31'h0, valid}, 32'd1);
        chk("rst_we", {31'h0, we}, 32'd0);
        chk("rst_waddr", {16'h0, waddr}, 32'd0);
        chk("rst_wdata", {20'h0, wdata}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        rst = 0;

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 11; i++) begin
            up = vecs[i].up; down = vecs[i].down; left = vecs[i].left; right = vecs[i].right;
            draw = vecs[i].draw; color = vecs[i].color;
            tick1();
            chk($sformatf("v%0d_x", i), {24'h0, x}, {24'h0, vecs[i].ex});
            chk($sformatf("v%0d_y", i), {24'h0, y}, {24'h0, vecs[i].ey});
            chk($sformatf("v%0d_we", i), {31'h0, we}, {31'h0, vecs[i].ewe});
            chk($sformatf("v%0d_waddr", i), {16'h0, waddr}, {16'h0, vecs[i].ewaddr});
            chk($sformatf("v%0d_wdata", i), {20'h0, wdata}, {20'h0, vecs[i].ewdata});
            chk($sformatf("v%0d_valid", i), {31'h0, valid}, 32'd1);
        end

        // Pen drawing with a move in the second cycle, via scoreboard
        do_reset();
        sb_en = 1;
        draw = 1; color = 12'h0F0;
        sb_q.push_back({16'h8080, 12'h0F0});
        tick1();
        right = 1;
        sb_q.push_back({16'h8080, 12'h0F0});
        tick1();
        sb_q.push_back({16'h8081, 12'h0F0});
        tick1();
        draw = 0; right = 0;
        tick1();
        chk("sb_drained", sb_q.size(), 32'd0);
        chk("draw_x", {24'h0, x}, 32'd129);
        sb_en = 0;

        // Press-and-hold auto-repeat
        do_reset();
        down = 1;
        tick1();
        chk("hold_first_y", {24'h0, y}, 32'd129);
        repeat (12) tick1();
        chk("hold_13_y", {24'h0, y}, 32'd132);
        down = 0;
        repeat (6) tick1();
        chk("hold_release_y", {24'h0, y}, 32'd132);
        chk("hold_x", {24'h0, x}, 32'd128);

        // Full clear with clear held throughout and up presses ignored
        clear = 1;
        tick1();
        n = 0;
        bad = 0;
        while (busy === 1'b1 && n < 70000) begin
            if (we !== 1'b1 || waddr !== n[15:0] || wdata !== 12'hFFF || valid !== 1'b0) bad++;
            up = (n < 60000) && ((n % 100) < 50);
            n++;
            tick1();
        end
        up = 0;
        chk("clear_len", n, 32'd65536);
        chk("clear_bad_cycles", bad, 32'd0);
        chk("clear_done_busy", {31'h0, busy}, 32'd0);
        chk("clear_done_valid", {31'h0, valid}, 32'd1);
        chk("clear_done_we", {31'h0, we}, 32'd0);
        chk("clear_y_kept", {24'h0, y}, 32'd132);
        repeat (5) tick1();
        chk("clear_no_retrigger", {31'h0, busy}, 32'd0);
        clear = 0;
        tick1();

        // Reset mid-clear aborts
        clear = 1;
        tick1();
        clear = 0;
        n = 0;
        while (waddr !== 16'd1000 && n < 5000) begin
            n++;
            tick1();
        end
        chk("abort_reached", {31'h0, (n < 5000)}, 32'd1);
        rst = 1;
        tick1();
        chk("abort_we", {31'h0, we}, 32'd0);
        chk("abort_busy", {31'h0, busy}, 32'd0);
        chk("abort_x", {24'h0, x}, 32'd128);
        chk("abort_y", {24'h0, y}, 32'd128);
        rst = 0;

`ifdef CURSOR_WRAP_EN
        edge_exp = 8'd0;
`else
        edge_exp = 8'd255;
`endif
        // Right edge of x
        do_reset();
        right = 1;
        n = 0;
        while (x !== 8'd255 && n < 2000) begin
            n++;
            tick1();
        end
        right = 0;
        chk("edge_x_reached", {24'h0, x}, 32'd255);
        tick1();
        right = 1;
        tick1();
        right = 0;
        chk("edge_x_step", {24'h0, x}, {24'h0, edge_exp});

        // Top edge of y
        do_reset();
        up = 1;
        n = 0;
        while (y !== 8'd0 && n < 2000) begin
            n++;
            tick1();
        end
        up = 0;
        chk("edge_y_reached", {24'h0, y}, 32'd0);
        tick1();
        up = 1;
        tick1();
        up = 0;
        chk("edge_y_step", {24'h0, y}, {24'h0, ~edge_exp});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
